uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Frame-atomic arbiter that shares the single UART transmit FIFO write port between two producers: requester 0 (downlink FEC control FSM) and requester 1 (uplink FEC engine). It grants ownership of the FIFO for one whole frame and uses round-robin fairness between frames. It passes writes through with zero latency and back-pressure on FIFO full, and revokes a stalled owner with a watchdog. The block sits between the FEC control logic and the UART, replacing the raw req/grant and wr0/wr1 muxing.

## Interface
Parameters:
- MDW, 8, UART data word width.
- FAW, 4, UART FIFO address width (level is FAW bits).
- WD_CYCLES, 1024, watchdog limit: idle cycles allowed while granted before revocation (≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  2  per-requester frame request; level, held until frame end.
- wr  in  2  per-requester write strobe.
- last  in  2  per-requester end-of-frame qualifier, valid with wr.
- wdata0  in  MDW  requester 0 data.
- wdata1  in  MDW  requester 1 data.
- grant  out  2  one-hot or zero ownership, registered.
- wready  out  2  wready[i] = grant[i] & ~tx_full.
- tx_full  in  1  UART TX FIFO full.
- tx_wr  out  1  FIFO write strobe (combinational).
- tx_wdata  out  MDW  FIFO write data (combinational mux).
- busy  out  1  high while state is OWN.
- frames_done  out  16  count of completed frames, wraps 0xFFFF→0.
- wd_err  out  2  sticky per-requester watchdog revocation flag.
- drop_err  out  2  sticky per-requester flag: wr while not granted.
- err_clr  in  1  synchronous clear of wd_err and drop_err.

## Operation
- States: IDLE, OWN.
- IDLE: if any req is high, select the winner. If both are high, the winner is the requester indicated by the priority pointer `ptr`; otherwise the single requester wins. On the next edge: grant[winner]=1, state=OWN, word counter=0, watchdog=0.
- OWN (owner g):
  - tx_wr = wr[g] & ~tx_full; tx_wdata = g ? wdata1 : wdata0. A write is accepted when tx_wr=1.
  - An accepted write increments the 8-bit word counter (saturating, internal/debug) and resets the watchdog.
  - Accepted write with last[g]=1: go to IDLE, grant=0, frames_done+1, ptr = ~g.
  - req[g] falls without last (abort): go to IDLE, grant=0, ptr = ~g, no frames_done increment. Any write in that same cycle is still forwarded if wready.
  - Watchdog counts cycles with no accepted write. Cycles with tx_full=1 do not count. At WD_CYCLES: go to IDLE, grant=0, wd_err[g] set, ptr = ~g.
- wr[i] while grant[i]=0: data is never forwarded and drop_err[i] is set. While wready[i]=0 but grant[i]=1 (FIFO full), wr is held off and is not an error.
- The non-owner's wr/last/data are ignored, apart from drop_err.
- err_clr clears both sticky vectors. If a set condition occurs in the same cycle, set wins.

## Timing
- Reset values: grant=0, wready=0, tx_wr=0, tx_wdata=0 (tx_wdata is forced to 0 when not OWN), busy=0, frames_done=0, wd_err=0, drop_err=0, ptr=0 (requester 0 favoured), state IDLE.
- Reset asserted mid-frame drops the grant asynchronously in the same cycle. No partial state survives reset.
- req sampled high in IDLE at edge n gives grant high after edge n (first write possible in cycle n+1).
- Write path latency is 0: tx_wr and tx_wdata follow wr in the same cycle.
- Last write accepted in cycle m gives grant=0 from edge m+1. The earliest next grant is after edge m+2 (one IDLE cycle minimum between frames).
- Both requesters re-requesting continuously strictly alternate frames.
- tx_full held high never triggers the watchdog. The owner keeps the grant indefinitely until the FIFO drains.
- tx_full rising in the same cycle as wr: the write is not accepted and the counter does not advance.
- frames_done increments on the edge ending the frame; 0xFFFF+1 → 0x0000.

## Test plan
- Single frame: req[0]=1, 5 writes 0xA1..0xA5 with last on 0xA5 → grant[0] after 1 cycle, tx_wr pulses 5 times with matching data, grant=0 next cycle, frames_done=1.
- Contention: req=2'b11 from reset, 3-word frames each, continuous requests → grant order 0,1,0,1 with one IDLE cycle between frames; frames_done=4 after four frames.
- Back-pressure: tx_full=1 for 2000 cycles mid-frame with WD_CYCLES=1024 → no tx_wr, no wd_err, grant held; the frame completes after tx_full drops.
- Watchdog: owner 1 granted, no writes for 1024 cycles → grant=0, wd_err=2'b10, next grant goes to requester 0 if requesting; err_clr → wd_err=0.
- Illegal write and abort: wr[1] with grant[1]=0 → tx_wr=0, drop_err[1]=1. Owner 0 drops req after 2 words → grant=0, frames_done unchanged, ptr=1.
- Reset mid-frame: rst pulse during OWN → grant/tx_wr/busy=0 immediately, counters and flags 0. After release, req[1] alone → grant[1] after 1 cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one UART TX FIFO write port between
// two producers, with zero-latency pass-through, back-pressure and a watchdog.
module uart_tx_arbiter #(
  parameter int MDW       = 8,
  parameter int FAW       = 4,
  parameter int WD_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req,
  input  logic [1:0]     wr,
  input  logic [1:0]     last,
  input  logic [MDW-1:0] wdata0,
  input  logic [MDW-1:0] wdata1,
  output logic [1:0]     grant,
  output logic [1:0]     wready,
  input  logic           tx_full,
  output logic           tx_wr,
  output logic [MDW-1:0] tx_wdata,
  output logic           busy,
  output logic [15:0]    frames_done,
  output logic [1:0]     wd_err,
  output logic [1:0]     drop_err,
  input  logic           err_clr,
  output logic [7:0]     word_cnt
);

  localparam int WD_W = $clog2(WD_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

  if (WD_CYCLES < 2 || FAW < 1) begin : g_param_check
    $error("uart_tx_arbiter: WD_CYCLES must be >= 2 and FAW >= 1");
  end

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            ptr_q, ptr_d;
  logic [7:0]      word_cnt_q, word_cnt_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [15:0]     frames_q, frames_d;
  logic [1:0]      wd_err_q, wd_err_d, wd_set;
  logic [1:0]      drop_err_q, drop_err_d;
  logic            accept;

  // Outputs decode registered state only, so reset removes the grant at once.
  assign busy     = (state_q == OWN);
  assign grant    = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign wready   = grant & {2{~tx_full}};
  assign tx_wr    = busy & wr[owner_q] & ~tx_full;
  assign tx_wdata = busy ? (owner_q ? wdata1 : wdata0) : '0;
  assign accept   = tx_wr;

  assign frames_done = frames_q;
  assign wd_err      = wd_err_q;
  assign drop_err    = drop_err_q;
  assign word_cnt    = word_cnt_q;

  // NOTE: every next-state variable gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    word_cnt_d = word_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    frames_d   = frames_q;
    wd_set     = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = OWN;
          owner_d    = (&req) ? ptr_q : req[1];
          word_cnt_d = '0;
          wd_cnt_d   = '0;
        end
      end
      OWN: begin
        if (accept) begin
          if (word_cnt_q != 8'hFF) word_cnt_d = word_cnt_q + 8'd1;
          wd_cnt_d = '0;
        end else if (!tx_full) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end

        // A completed frame takes precedence over a simultaneous req drop.
        if (accept && last[owner_q]) begin
          state_d  = IDLE;
          ptr_d    = ~owner_q;
          frames_d = frames_q + 16'd1;
        end else if (!req[owner_q]) begin
          state_d = IDLE;
          ptr_d   = ~owner_q;
        end else if (!accept && !tx_full && wd_cnt_q == WD_LAST) begin
          state_d         = IDLE;
          ptr_d           = ~owner_q;
          wd_set[owner_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    wd_err_d   = (err_clr ? 2'b00 : wd_err_q) | wd_set;
    drop_err_d = (err_clr ? 2'b00 : drop_err_q) | (wr & ~grant);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      ptr_q      <= 1'b0;
      word_cnt_q <= '0;
      wd_cnt_q   <= '0;
      frames_q   <= '0;
      wd_err_q   <= '0;
      drop_err_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      word_cnt_q <= word_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      frames_q   <= frames_d;
      wd_err_q   <= wd_err_d;
      drop_err_q <= drop_err_d;
    end
  end

endmodule
